// File: rtl/systolic_tile_sequencer.sv
// Purpose : drives the systolic controller through a job of num_tiles weight tiles (weight load, one compute pass, drain, repeat).
// Latency : registered outputs; per tile N_SIZE load cycles + controller turnaround + one compute pass; job_done 1 cycle after the last drain.
// Backpressure: waits on ctrl_ready before every load and compute phase; start is ignored while cmd_ready=0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, num_tiles      job request (accepted on start & cmd_ready), tile count sampled on accept
//   cmd_ready             idle, can accept a job
//   ctrl_ready, ctrl_done controller idle indication and compute-done pulse
//   load_weight, valid_in weight-load request and compute-valid to the controller
//   wt_rd_en, wt_rd_addr  weight-buffer read strobe and row address (tile_idx*N_SIZE + row)
//   tile_idx              index of the tile in flight
//   job_done              one-cycle pulse when the job completes
//   error                 sticky compute-watchdog error
//
// Optional: define SEQ_WATCHDOG_EN to abort a compute pass that never sees ctrl_done;
// without it, error is tied low and the compute phase waits indefinitely.
module systolic_tile_sequencer #(
    parameter int N_SIZE        = 32,
    parameter int NUM_ROWS      = 512,
    parameter int TILE_W        = 8,
    parameter int WT_ADDR_WIDTH = 13,
    parameter int TIMEOUT_SLACK = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [TILE_W-1:0]        num_tiles,
    output logic                     cmd_ready,
    input  logic                     ctrl_ready,
    input  logic                     ctrl_done,
    output logic                     load_weight,
    output logic                     valid_in,
    output logic                     wt_rd_en,
    output logic [WT_ADDR_WIDTH-1:0] wt_rd_addr,
    output logic [TILE_W-1:0]        tile_idx,
    output logic                     job_done,
    output logic                     error
);

    localparam int KW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
    localparam logic [KW-1:0]            K_LAST = KW'(N_SIZE - 1);
    localparam logic [WT_ADDR_WIDTH-1:0] N_ADDR = WT_ADDR_WIDTH'(N_SIZE);

    // Elaboration-time sanity: the weight buffer must address every row of the largest job.
    if (((1 << TILE_W) * N_SIZE - 1) >= (1 << WT_ADDR_WIDTH)) begin : g_bad_addr_width
        $error("WT_ADDR_WIDTH too small for 2^TILE_W*N_SIZE rows");
    end
    if (NUM_ROWS < 1 || TIMEOUT_SLACK < 0) begin : g_bad_cfg
        $error("NUM_ROWS must be positive and TIMEOUT_SLACK non-negative");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD_WAIT, S_WLOAD, S_CMP_WAIT, S_COMPUTE, S_DRAIN
    } state_t;

    state_t                     state_q, state_d;
    logic [TILE_W-1:0]          num_q, num_d;
    logic [TILE_W-1:0]          tile_q, tile_d;
    logic [KW-1:0]              k_q, k_d;
    logic [WT_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       load_q, load_d;
    logic                       valid_q, valid_d;
    logic                       rd_en_q, rd_en_d;
    logic                       done_q, done_d;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_LIMIT = NUM_ROWS + 2 * N_SIZE + TIMEOUT_SLACK;
    localparam int WDW      = $clog2(WD_LIMIT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        tile_d      = tile_q;
        k_d         = k_q;
        addr_d      = addr_q;
        cmd_ready_d = cmd_ready_q;
        load_d      = load_q;
        valid_d     = valid_q;
        rd_en_d     = rd_en_q;
        done_d      = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && cmd_ready_q) begin
                    num_d  = num_tiles;
                    tile_d = '0;
`ifdef SEQ_WATCHDOG_EN
                    err_d  = 1'b0;
`endif
                    // An empty job completes at once; cmd_ready never drops.
                    if (num_tiles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cmd_ready_d = 1'b0;
                        state_d     = S_WLOAD_WAIT;
                    end
                end
            end
            S_WLOAD_WAIT: begin
                if (ctrl_ready) begin
                    state_d = S_WLOAD;
                    load_d  = 1'b1;
                    rd_en_d = 1'b1;
                    k_d     = '0;
                    addr_d  = WT_ADDR_WIDTH'(tile_q) * N_ADDR;
                end
            end
            S_WLOAD: begin
                if (k_q == K_LAST) begin
                    load_d  = 1'b0;
                    rd_en_d = 1'b0;
                    state_d = S_CMP_WAIT;
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            S_CMP_WAIT: begin
                if (ctrl_ready) begin
                    state_d = S_COMPUTE;
                    valid_d = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            S_COMPUTE: begin
                if (ctrl_done) begin
                    valid_d = 1'b0;
                    state_d = S_DRAIN;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    // Abort the job: no job_done, back to idle with the error flagged.
                    err_d       = 1'b1;
                    valid_d     = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (ctrl_ready) begin
                    if (tile_q == num_q - 1'b1) begin
                        done_d      = 1'b1;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = S_WLOAD_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            tile_q      <= '0;
            k_q         <= '0;
            addr_q      <= '0;
            cmd_ready_q <= 1'b1;
            load_q      <= 1'b0;
            valid_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            tile_q      <= tile_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            cmd_ready_q <= cmd_ready_d;
            load_q      <= load_d;
            valid_q     <= valid_d;
            rd_en_q     <= rd_en_d;
            done_q      <= done_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign cmd_ready   = cmd_ready_q;
    assign load_weight = load_q;
    assign valid_in    = valid_q;
    assign wt_rd_en    = rd_en_q;
    assign wt_rd_addr  = addr_q;
    assign tile_idx    = tile_q;
    assign job_done    = done_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Purpose : bench for systolic_tile_sequencer with a behavioural controller (N_SIZE=4, NUM_ROWS=8).
// Latency : controller returns ctrl_done after NUM_ROWS+2*N_SIZE-1 valid cycles.
// Backpressure: ctrl_ready low while loading/computing, or while the bench forces a hold.
module tb_systolic_tile_sequencer;

    localparam int N  = 4;
    localparam int NR = 8;
    localparam int TW = 8;
    localparam int AW = 13;
    localparam int SL = 16;
    localparam int BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] num_tiles = '0;
    logic          cmd_ready;
    logic          ctrl_ready;
    logic          ctrl_done;
    logic          load_weight;
    logic          valid_in;
    logic          wt_rd_en;
    logic [AW-1:0] wt_rd_addr;
    logic [TW-1:0] tile_idx;
    logic          job_done;
    logic          error;

    logic ctrl_hold = 1'b0;
    logic no_done   = 1'b0;
    int   mcnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    systolic_tile_sequencer #(
        .N_SIZE(N), .NUM_ROWS(NR), .TILE_W(TW), .WT_ADDR_WIDTH(AW), .TIMEOUT_SLACK(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .cmd_ready(cmd_ready), .ctrl_ready(ctrl_ready), .ctrl_done(ctrl_done),
        .load_weight(load_weight), .valid_in(valid_in), .wt_rd_en(wt_rd_en),
        .wt_rd_addr(wt_rd_addr), .tile_idx(tile_idx), .job_done(job_done), .error(error)
    );

    // Behavioural controller: busy while loading or computing, done after NR+2N-1 valid cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ready <= 1'b1;
            ctrl_done  <= 1'b0;
            mcnt       <= 0;
        end else begin
            ctrl_done <= 1'b0;
            if (valid_in && !ctrl_done) begin
                if (mcnt == NR + 2 * N - 2) begin
                    mcnt <= 0;
                    if (!no_done) ctrl_done <= 1'b1;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
            ctrl_ready <= !ctrl_hold && !load_weight && !(valid_in && !ctrl_done);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n;          // num_tiles
        int hold;       // cycles of forced ctrl_ready=0 after the first pass (0 = none)
        int mid_start;  // pulse start with num_tiles=7 mid-job
        int exp_lw;     // load_weight cycles
        int exp_pass;   // compute passes
        int exp_lat;    // cycles from accept to job_done (-1 = not checked)
        int exp_last;   // last tile index seen while active
    } vec_t;

    vec_t vecs[4];

    task automatic run_job(input vec_t v, input string tag);
        int cyc = 0, lw_cnt = 0, passes = 0, jd_cnt = 0, bad_addr = 0, overlap = 0;
        int exp_addr = 0, lat = -1, last_tile = 0, hold_left = 0, lw_in_hold = 0;
        int err_seen = 0, tail = 0;
        bit vprev = 1'b0, held = 1'b0;
        @(negedge clk);
        num_tiles = TW'(v.n);
        start     = 1'b1;
        while (cyc < BUDGET && tail < 3) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (load_weight) begin
                lw_cnt++;
                if (!wt_rd_en || int'(wt_rd_addr) != exp_addr || int'(tile_idx) != exp_addr / N)
                    bad_addr++;
                exp_addr++;
            end else if (wt_rd_en) begin
                bad_addr++;
            end
            if (load_weight && valid_in) overlap++;
            if (load_weight || valid_in) last_tile = int'(tile_idx);
            if (error) err_seen++;
            if (job_done) begin
                jd_cnt++;
                if (lat < 0) lat = cyc;
            end
            if (jd_cnt > 0) tail++;
            if (hold_left > 0) begin
                if (load_weight) lw_in_hold++;
                hold_left--;
                if (hold_left == 0) ctrl_hold = 1'b0;
            end else if (v.hold > 0 && !held && vprev && !valid_in) begin
                held      = 1'b1;
                ctrl_hold = 1'b1;
                hold_left = v.hold;
            end
            if (valid_in && !vprev) passes++;
            vprev = valid_in;
            if (v.mid_start != 0 && cyc == 10) begin
                start = 1'b1; num_tiles = 8'd7;
            end else if (v.mid_start != 0 && cyc == 11) begin
                start = 1'b0; num_tiles = TW'(v.n);
            end
        end
        ctrl_hold = 1'b0;
        check({tag, " job_done count"}, jd_cnt, 1);
        check({tag, " load cycles"}, lw_cnt, v.exp_lw);
        check({tag, " compute passes"}, passes, v.exp_pass);
        check({tag, " bad addr/tile cycles"}, bad_addr, 0);
        check({tag, " load/valid overlap"}, overlap, 0);
        check({tag, " cmd_ready after job"}, int'(cmd_ready), 1);
        check({tag, " error cycles"}, err_seen, 0);
        if (v.exp_lat >= 0) check({tag, " job_done latency"}, lat, v.exp_lat);
        if (v.n > 0) check({tag, " last tile_idx"}, last_tile, v.exp_last);
        if (v.hold > 0) begin
            check({tag, " hold engaged"}, int'(held), 1);
            check({tag, " load during hold"}, lw_in_hold, 0);
        end
    endtask

    initial begin
        int waited;
        vecs[0] = '{1, 0,  0, 4,  1, -1, 0};
        vecs[1] = '{3, 0,  0, 12, 3, -1, 2};
        vecs[2] = '{0, 0,  0, 0,  0, 1,  0};
        vecs[3] = '{2, 10, 1, 8,  2, -1, 1};

        // Reset and idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset load_weight", int'(load_weight), 0);
        check("reset valid_in", int'(valid_in), 0);
        check("reset wt_rd_en", int'(wt_rd_en), 0);
        check("reset wt_rd_addr", int'(wt_rd_addr), 0);
        check("reset tile_idx", int'(tile_idx), 0);
        check("reset job_done", int'(job_done), 0);
        check("reset error", int'(error), 0);

        foreach (vecs[i]) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // Reset asserted during the second tile's compute pass.
        @(negedge clk);
        num_tiles = 8'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (waited < BUDGET && !(valid_in && tile_idx == 8'd1)) begin
            @(negedge clk);
            waited++;
        end
        check("midreset reached tile1 compute", int'(valid_in && tile_idx == 8'd1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset cmd_ready", int'(cmd_ready), 1);
        check("midreset valid_in", int'(valid_in), 0);
        check("midreset load_weight", int'(load_weight), 0);
        check("midreset wt_rd_en", int'(wt_rd_en), 0);
        check("midreset wt_rd_addr", int'(wt_rd_addr), 0);
        check("midreset tile_idx", int'(tile_idx), 0);
        check("midreset job_done", int'(job_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_job(vecs[0], "post-reset");

`ifdef SEQ_WATCHDOG_EN
        begin
            int vcnt = 0, jd = 0;
            no_done = 1'b1;
            @(negedge clk);
            num_tiles = 8'd1;
            start     = 1'b1;
            @(negedge clk);
            start  = 1'b0;
            waited = 0;
            while (waited < BUDGET && !error) begin
                if (valid_in) vcnt++;
                if (job_done) jd++;
                @(negedge clk);
                waited++;
            end
            check("wdog error raised", int'(error), 1);
            check("wdog valid cycles", vcnt, NR + 2 * N + SL);
            check("wdog valid_in low", int'(valid_in), 0);
            check("wdog cmd_ready", int'(cmd_ready), 1);
            repeat (3) begin
                if (job_done) jd++;
                @(negedge clk);
            end
            check("wdog no job_done", jd, 0);
            check("wdog error sticky", int'(error), 1);
            no_done   = 1'b0;
            num_tiles = 8'd0;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("wdog error cleared by start", int'(error), 0);
            check("wdog empty job done", int'(job_done), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
